// File: rtl/glay_read_burst_issuer.sv
// glay_read_burst_issuer
// Read-request front end for one AXI4 master channel. A byte-range command is
// split into bursts that never cross a C_BURST_BEATS*BB boundary, which also
// keeps every burst inside one 4 KiB page. The bursts are driven on AR. The
// number of bursts in flight is tracked by an external transaction counter
// that this block drives through load/incr/decr. done pulses once every
// issued burst has returned its RLAST.
//
// Ports
//   ap_clk, areset          clock, asynchronous active-high reset
//   cmd_valid/ready         command handshake
//   cmd_addr, cmd_len       start byte address and byte length (low bits ignored)
//   m_axi_ar*               AR channel (valid, ready, addr, len)
//   m_axi_rvalid/rready/rlast  R channel, observed only
//   ctr_load/load_value/incr/decr  controls to the transaction counter
//   ctr_count, ctr_is_zero  registered state from the transaction counter
//   busy                    high whenever a command is being processed
//   done                    one-cycle pulse at command completion
module glay_read_burst_issuer #(
   parameter int C_ADDR_WIDTH      = 64,
   parameter int C_LEN_WIDTH       = 32,
   parameter int C_DATA_WIDTH      = 512,
   parameter int C_BURST_BEATS     = 64,
   parameter int C_MAX_OUTSTANDING = 16,
   parameter int C_CNT_WIDTH       = 5
) (
   input  logic                    ap_clk,
   input  logic                    areset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [C_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [C_LEN_WIDTH-1:0]  cmd_len,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   input  logic                    m_axi_rvalid,
   input  logic                    m_axi_rready,
   input  logic                    m_axi_rlast,
   output logic                    ctr_load,
   output logic [C_CNT_WIDTH-1:0]  ctr_load_value,
   output logic                    ctr_incr,
   output logic                    ctr_decr,
   input  logic [C_CNT_WIDTH-1:0]  ctr_count,
   input  logic                    ctr_is_zero,
   output logic                    busy,
   output logic                    done
);

   localparam int BB     = C_DATA_WIDTH / 8;
   localparam int OFF_W  = $clog2(BB);
   localparam int BEAT_W = $clog2(C_BURST_BEATS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [C_ADDR_WIDTH-1:0] addr;        // address of the next burst to issue
   logic [C_LEN_WIDTH-1:0]  beats_rem;   // beats not yet placed on AR
   logic [C_LEN_WIDTH-1:0]  cmd_beats;
   logic [BEAT_W:0]         room;
   logic [BEAT_W:0]         burst_beats;
   logic                    cmd_hs;
   logic                    ar_free;
   logic                    slot_free;
   logic                    issue_go;

   assign cmd_beats = cmd_len >> OFF_W;
   assign cmd_hs    = cmd_valid && (state == IDLE);

   // Beats left before the next C_BURST_BEATS-aligned boundary.
   assign room        = (BEAT_W+1)'(C_BURST_BEATS) - {1'b0, addr[OFF_W +: BEAT_W]};
   assign burst_beats = (beats_rem < C_LEN_WIDTH'(room)) ? beats_rem[BEAT_W:0] : room;

   // The AR register can take a new burst when empty or being drained this cycle.
   assign ar_free = !m_axi_arvalid || m_axi_arready;

   // ctr_count does not yet include a burst sitting on AR, so count it here;
   // otherwise a back-to-back issue would overshoot the limit by one.
   assign slot_free = ({1'b0, ctr_count} + (C_CNT_WIDTH+1)'(m_axi_arvalid))
                      < (C_CNT_WIDTH+1)'(C_MAX_OUTSTANDING);

   assign issue_go = (state == ISSUE) && (beats_rem != '0) && ar_free && slot_free;

   assign ctr_incr       = m_axi_arvalid && m_axi_arready;
   assign ctr_decr       = m_axi_rvalid && m_axi_rready && m_axi_rlast;
   assign ctr_load       = cmd_hs;
   assign ctr_load_value = '0;

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               state_nxt = (cmd_beats != '0) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if ((beats_rem == '0) && ar_free) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (ctr_is_zero) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         state         <= IDLE;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
      end else begin
         state <= state_nxt;
         if (issue_go) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= addr;
            m_axi_arlen   <= 8'(burst_beats - (BEAT_W+1)'(1));
         end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
         end
      end
   end

   // addr/beats_rem are advanced when a burst is loaded onto AR, so they always
   // describe the burst that follows the one currently presented.
   always_ff @(posedge ap_clk) begin
      if (cmd_hs) begin
         addr      <= cmd_addr & ~C_ADDR_WIDTH'(BB - 1);
         beats_rem <= cmd_beats;
      end else if (issue_go) begin
         addr      <= addr + (C_ADDR_WIDTH'(burst_beats) << OFF_W);
         beats_rem <= beats_rem - C_LEN_WIDTH'(burst_beats);
      end
   end

endmodule

// File: doc/glay_read_burst_issuer.md
Name: glay_read_burst_issuer

Overview:
Read-request front end for one AXI4 master channel. Accepts a byte-range command, splits it into 4 KiB-safe AXI read bursts, and drives AR. Throttles outstanding bursts by driving load/incr/decr into the downstream glay_transactions_counter and reading back its count/is_zero. Pulses done once every issued burst has returned its RLAST.

Parameters:
C_ADDR_WIDTH, 64, byte address width.
C_LEN_WIDTH, 32, command length width in bytes.
C_DATA_WIDTH, 512, AXI data width in bits; beat size BB = C_DATA_WIDTH/8 bytes.
C_BURST_BEATS, 64, max beats per burst; power of 2, ≤256, C_BURST_BEATS*BB ≤ 4096.
C_MAX_OUTSTANDING, 16, max bursts in flight.
C_CNT_WIDTH, 5, counter width; ≥ clog2(C_MAX_OUTSTANDING+1).

Ports:
ap_clk  in  1  clock.
areset  in  1  asynchronous reset, active-high.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command ready.
cmd_addr  in  C_ADDR_WIDTH  start byte address, BB-aligned.
cmd_len  in  C_LEN_WIDTH  length in bytes, multiple of BB.
m_axi_arvalid  out  1  AR valid.
m_axi_arready  in  1  AR ready.
m_axi_araddr  out  C_ADDR_WIDTH  burst address.
m_axi_arlen  out  8  beats-1.
m_axi_rvalid  in  1  R valid (monitor only).
m_axi_rready  in  1  R ready (monitor only).
m_axi_rlast  in  1  R last (monitor only).
ctr_load  out  1  to counter load.
ctr_load_value  out  C_CNT_WIDTH  to counter load_value; constant 0.
ctr_incr  out  1  to counter incr.
ctr_decr  out  1  to counter decr.
ctr_count  in  C_CNT_WIDTH  from counter count.
ctr_is_zero  in  1  from counter is_zero.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, state cleared immediately): state IDLE, arvalid 0, araddr 0, arlen 0, done 0, busy 0, ctr_load 0; cmd_ready 1 from first cycle after release. Counter ap_clken tied high.
- ctr_incr = arvalid & arready (combinational). ctr_decr = rvalid & rready & rlast (combinational, in every state, including IDLE). Both high same cycle is legal; counter holds.
- Low log2(BB) bits of cmd_addr/cmd_len are ignored (truncated).
- FSM IDLE: cmd_ready=1. On cmd_valid&cmd_ready: latch addr; beats_rem = cmd_len/BB; ctr_load=1 for that cycle; next ISSUE if beats_rem≠0, else DONE.
- FSM ISSUE: burst beats b = min(beats_rem, C_BURST_BEATS − ((addr/BB) mod C_BURST_BEATS)). araddr/arlen registered, arlen = b−1. Raise arvalid only when ctr_count < C_MAX_OUTSTANDING. Once raised, arvalid/araddr/arlen hold stable until arready. On handshake: addr += b*BB, beats_rem −= b; next AR may be valid the following cycle. When beats_rem hits 0 → DRAIN.
- FSM DRAIN: wait for ctr_is_zero=1 (registered, reflects decr one cycle later) → DONE.
- FSM DONE: done=1 one cycle → IDLE.
- Throughput: one AR per cycle when arready held high and not throttled.
- No burst crosses a C_BURST_BEATS*BB boundary (hence no 4 KiB crossing).
- rlast arriving with counter already zero: driven through; counter wrap is a system error, not handled here.

Test Plan:
(Defaults: BB=64, 4096-byte bursts, MAX=16, arready=1, R returns 1 beat/cycle unless stated.)
- addr 0x0, len 16384 -> 4 ARs araddr 0x0,0x1000,0x2000,0x3000, arlen 63 each on consecutive cycles; done one cycle after ctr_is_zero rises after 4th rlast.
- addr 0x0F80, len 512 -> AR1 araddr 0x0F80 arlen 1; AR2 araddr 0x1000 arlen 5; no further AR.
- len 81920 (20 bursts), R held off -> exactly 16 AR handshakes then arvalid 0; first rlast -> 17th AR issued after count drops to 15.
- len 0 -> cmd accepted, ctr_load pulse, done=1 next cycle, no arvalid, back to IDLE.
- areset mid-ISSUE after 2 ARs with arvalid high -> arvalid/busy drop asynchronously; cmd_ready 1 after release; fresh command issues from its own address.
- AR handshake coincident with rlast -> ctr_incr=ctr_decr=1 same cycle; ctr_count unchanged next cycle.
